// File: rtl/ppu_special_bypass.sv
// Dispatcher/merger around a fixed-latency posit core: special or trivial ops are resolved
// locally, regular ops go to the core, and results are merged in issue order into an output FIFO.

package ppu_pkg;
    localparam int unsigned OP_BITS = 2;
    localparam logic [OP_BITS-1:0] OP_ADD = 2'd0;
    localparam logic [OP_BITS-1:0] OP_SUB = 2'd1;
    localparam logic [OP_BITS-1:0] OP_MUL = 2'd2;
    localparam logic [OP_BITS-1:0] OP_DIV = 2'd3;
endpackage

// Result of an op with a ZERO/NAR operand or a trivially cancelling ADD/SUB.
module handle_special_or_trivial
    import ppu_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic [OP_BITS-1:0] op_i,
    input  logic [N-1:0]       p1_i,
    input  logic [N-1:0]       p2_i,
    output logic [N-1:0]       res_c_o
);
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    logic [N-1:0] neg_p2;

    assign neg_p2 = (~p2_i) + N'(1);

    always_comb begin
        res_c_o = '0;
        if (p1_i == NAR || p2_i == NAR) begin
            res_c_o = NAR;
        end else begin
            unique case (op_i)
                OP_ADD: begin
                    if (p1_i == '0)      res_c_o = p2_i;
                    else if (p2_i == '0) res_c_o = p1_i;
                end
                OP_SUB: begin
                    if (p1_i == '0)      res_c_o = neg_p2;
                    else if (p2_i == '0) res_c_o = p1_i;
                end
                OP_DIV: begin
                    if (p2_i == '0)      res_c_o = NAR;
                end
                default: res_c_o = '0;
            endcase
        end
    end
endmodule

module ppu_special_bypass
    import ppu_pkg::*;
#(
    parameter int unsigned N            = 16,
    parameter int unsigned CORE_LATENCY = 3,
    parameter int unsigned DEPTH        = CORE_LATENCY + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_BITS-1:0] op,
    input  logic [N-1:0]       p1,
    input  logic [N-1:0]       p2,
    output logic               core_valid,
    output logic [OP_BITS-1:0] core_op,
    output logic [N-1:0]       core_p1,
    output logic [N-1:0]       core_p2,
    input  logic [N-1:0]       core_pout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       pout,
    output logic               out_special
);
    localparam int unsigned L  = CORE_LATENCY;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    logic           acc_c;
    logic           special_c;
    logic           push_c;
    logic           pop_c;
    logic [N-1:0]   neg_p1_c;
    logic [N-1:0]   lut_res_c;
    logic [N-1:0]   push_data_c;

    logic [L-1:0]   vld_q, vld_d;
    logic [L-1:0]   spc_q, spc_d;
    logic [N-1:0]   res_q [L];
    logic [N-1:0]   res_d [L];

    logic [N:0]     mem_q [DEPTH];
    logic [PW-1:0]  wr_q, wr_d;
    logic [PW-1:0]  rd_q, rd_d;
    logic [CW-1:0]  fcnt_q, fcnt_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    handle_special_or_trivial #(.N(N)) u_special (
        .op_i    (op),
        .p1_i    (p1),
        .p2_i    (p2),
        .res_c_o (lut_res_c)
    );

    // Credits bound in-flight plus buffered results, so the FIFO can never overflow.
    assign in_ready  = (cnt_q < CW'(DEPTH));
    assign acc_c     = in_valid && in_ready;
    assign neg_p1_c  = (~p1) + N'(1);
    assign special_c = (p1 == '0) || (p1 == NAR) || (p2 == '0) || (p2 == NAR) ||
                       ((op == OP_ADD) && (p2 == neg_p1_c)) ||
                       ((op == OP_SUB) && (p1 == p2));

    assign core_valid = acc_c && !special_c;
    assign core_op    = op;
    assign core_p1    = p1;
    assign core_p2    = p2;

    assign out_valid            = (fcnt_q != '0);
    assign {out_special, pout}  = mem_q[rd_q];
    assign pop_c                = out_valid && out_ready;
    assign push_c               = vld_q[L-1];
    assign push_data_c          = spc_q[L-1] ? res_q[L-1] : core_pout;

    always_comb begin
        vld_d  = '0;
        spc_d  = '0;
        res_d  = res_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        fcnt_d = fcnt_q;
        cnt_d  = cnt_q;

        vld_d[0] = acc_c;
        spc_d[0] = special_c;
        res_d[0] = lut_res_c;
        for (int k = 1; k < int'(L); k++) begin
            vld_d[k] = vld_q[k-1];
            spc_d[k] = spc_q[k-1];
            res_d[k] = res_q[k-1];
        end

        if (push_c) wr_d = ptr_inc(wr_q);
        if (pop_c)  rd_d = ptr_inc(rd_q);

        unique case ({push_c, pop_c})
            2'b10:   fcnt_d = fcnt_q + CW'(1);
            2'b01:   fcnt_d = fcnt_q - CW'(1);
            default: fcnt_d = fcnt_q;
        endcase

        unique case ({acc_c, pop_c})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            spc_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
            cnt_q  <= '0;
            for (int k = 0; k < int'(L); k++)     res_q[k] <= '0;
            for (int k = 0; k < int'(DEPTH); k++) mem_q[k] <= '0;
        end else begin
            vld_q  <= vld_d;
            spc_q  <= spc_d;
            res_q  <= res_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            fcnt_q <= fcnt_d;
            cnt_q  <= cnt_d;
            if (push_c) mem_q[wr_q] <= {spc_q[L-1], push_data_c};
        end
    end
endmodule

// File: tb/tb_ppu_special_bypass.sv
// Bench for ppu_special_bypass: a fake fixed-latency core plus an in-order result model.
module tb_ppu_special_bypass;
    import ppu_pkg::*;

    localparam int unsigned N     = 16;
    localparam int unsigned L     = 3;
    localparam int unsigned DEPTH = L + 2;
    localparam logic [15:0] NAR   = 16'h8000;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [OP_BITS-1:0] op = '0;
    logic [N-1:0]       p1 = '0;
    logic [N-1:0]       p2 = '0;
    logic               core_valid;
    logic [OP_BITS-1:0] core_op;
    logic [N-1:0]       core_p1;
    logic [N-1:0]       core_p2;
    logic [N-1:0]       core_pout;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [N-1:0]       pout;
    logic               out_special;

    always #5 clk = ~clk;

    ppu_special_bypass #(.N(N), .CORE_LATENCY(L), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .p1          (p1),
        .p2          (p2),
        .core_valid  (core_valid),
        .core_op     (core_op),
        .core_p1     (core_p1),
        .core_p2     (core_p2),
        .core_pout   (core_pout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pout        (pout),
        .out_special (out_special)
    );

    // Fake core: multiplying by 1.0 returns p1, anything else a recognisable hash.
    function automatic logic [15:0] fake_core(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        if (o == OP_MUL && b == 16'h4000) return a;
        return a ^ {b[7:0], b[15:8]} ^ 16'(o);
    endfunction

    logic        cap_v = 1'b0;
    logic [15:0] cap_d = 16'h0;
    logic [15:0] cpipe [1:L];

    always @(negedge clk) begin
        cap_v = core_valid;
        cap_d = fake_core(core_op, core_p1, core_p2);
    end

    always @(posedge clk) begin
        cpipe[1] <= cap_v ? cap_d : 16'hDEAD;
        for (int k = 2; k <= int'(L); k++) cpipe[k] <= cpipe[k-1];
    end
    assign core_pout = cpipe[L];

    // Reference: classification and result straight from the arithmetic rules.
    task automatic ref_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          output bit sp, output logic [15:0] r);
        bit za, zb, xa, xb;
        za = (a == 16'h0); zb = (b == 16'h0);
        xa = (a == NAR);   xb = (b == NAR);
        sp = za || zb || xa || xb || (o == OP_ADD && 16'(a + b) == 16'h0) || (o == OP_SUB && a == b);
        r  = 16'h0;
        if (!sp) r = fake_core(o, a, b);
        else if (xa || xb) r = NAR;
        else if (o == OP_ADD) r = za ? b : (zb ? a : 16'h0);
        else if (o == OP_SUB) r = za ? 16'(16'h0 - b) : (zb ? a : 16'h0);
        else if (o == OP_DIV) r = zb ? NAR : 16'h0;
    endtask

    typedef struct {
        logic [15:0] pout;
        bit          sp;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] p1;
        logic [15:0] p2;
        logic [15:0] pout;
        bit          sp;
    } vec_t;

    exp_t q[$];
    vec_t tab [14];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   mcnt  = 0;
    int   nacc  = 0;
    int   nov   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive, check against the model at negedge, update the model.
    task automatic step(input bit v, input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input bit ordy, input bit use_tab, input logic [15:0] tp, input bit tsp);
        bit          acc, exp_ov, sp;
        logic [15:0] r;
        exp_t        e;
        in_valid  = v;
        op        = o;
        p1        = a;
        p2        = b;
        out_ready = ordy;
        @(negedge clk);
        cyc++;
        chk("in_ready", in_ready, 32'(mcnt < int'(DEPTH)));
        acc = v && (mcnt < int'(DEPTH));
        ref_op(o, a, b, sp, r);
        if (use_tab) begin
            r  = tp;
            sp = tsp;
        end
        chk("core_valid", core_valid, 32'(acc && !sp));
        exp_ov = (q.size() > 0) && (cyc >= q[0].cyc + int'(L) + 1);
        chk("out_valid", out_valid, 32'(exp_ov));
        if (exp_ov) nov++;
        if (exp_ov && ordy) begin
            e = q.pop_front();
            if (out_valid) begin
                chk("pout", pout, 32'(e.pout));
                chk("out_special", out_special, 32'(e.sp));
            end
            mcnt--;
        end
        if (acc) begin
            e.pout = r;
            e.sp   = sp;
            e.cyc  = cyc;
            q.push_back(e);
            mcnt++;
            nacc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 16'h0, 16'h0, ordy, 1'b0, 16'h0, 1'b0);
    endtask

    function automatic logic [15:0] pick();
        int s;
        s = int'($urandom_range(0, 9));
        if (s == 0) return 16'h0000;
        if (s == 1) return NAR;
        if (s == 2) return 16'h4000;
        if (s == 3) return 16'hC000;
        return 16'($urandom);
    endfunction

    task automatic rnd_step(input bit v, input bit ordy);
        logic [1:0]  o;
        logic [15:0] a, b;
        int          s;
        o = 2'($urandom_range(0, 3));
        a = pick();
        b = pick();
        s = int'($urandom_range(0, 5));
        if (s == 0) b = 16'(16'h0 - a);
        else if (s == 1) b = a;
        step(v, o, a, b, ordy, 1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        for (int k = 1; k <= int'(L); k++) cpipe[k] = 16'h0;

        tab[0]  = '{OP_MUL, 16'h4000, 16'h4000, 16'h4000, 1'b0};
        tab[1]  = '{OP_MUL, 16'h0000, 16'h4000, 16'h0000, 1'b1};
        tab[2]  = '{OP_DIV, 16'h4000, 16'h0000, 16'h8000, 1'b1};
        tab[3]  = '{OP_ADD, 16'h4000, 16'hC000, 16'h0000, 1'b1};
        tab[4]  = '{OP_SUB, 16'h3000, 16'h3000, 16'h0000, 1'b1};
        tab[5]  = '{OP_ADD, 16'h8000, 16'h1000, 16'h8000, 1'b1};
        tab[6]  = '{OP_ADD, 16'h4000, 16'h3000, 16'h4030, 1'b0};
        tab[7]  = '{OP_SUB, 16'h0000, 16'h3000, 16'hD000, 1'b1};
        tab[8]  = '{OP_SUB, 16'h5000, 16'h1200, 16'h5013, 1'b0};
        tab[9]  = '{OP_ADD, 16'h0000, 16'h3000, 16'h3000, 1'b1};
        tab[10] = '{OP_DIV, 16'h7000, 16'h4800, 16'h704B, 1'b0};
        tab[11] = '{OP_MUL, 16'h8000, 16'h0000, 16'h8000, 1'b1};
        tab[12] = '{OP_SUB, 16'h5000, 16'h0000, 16'h5000, 1'b1};
        tab[13] = '{OP_DIV, 16'h0000, 16'h5000, 16'h0000, 1'b1};

        // Held in reset: nothing valid, ready asserted.
        idle(2, 1'b1);
        rst = 1'b1;
        idle(1, 1'b1);

        // Directed vectors back to back, including regular/special interleave.
        for (int i = 0; i < 14; i++)
            step(1'b1, tab[i].op, tab[i].p1, tab[i].p2, 1'b1, 1'b1, tab[i].pout, tab[i].sp);
        idle(int'(L) + 3, 1'b1);

        // Backpressure: exactly DEPTH accepts, then release while still offering.
        nacc = 0;
        for (int i = 0; i < 8; i++) rnd_step(1'b1, 1'b0);
        chk("bp_accepts", 32'(nacc), 32'(DEPTH));
        for (int i = 0; i < 12; i++) rnd_step(1'b1, 1'b1);
        idle(int'(DEPTH + L) + 3, 1'b1);
        chk("bp_drained", 32'(q.size()), 32'd0);

        // Full-throughput stream: no bubbles on either side.
        nov  = 0;
        base = nacc;
        for (int i = 0; i < 100; i++) rnd_step(1'b1, 1'b1);
        idle(int'(L) + 1, 1'b1);
        chk("stream_accepts", 32'(nacc - base), 32'd100);
        chk("stream_no_bubble", 32'(nov), 32'd100);

        // Random valid/ready mix.
        for (int i = 0; i < 400; i++) rnd_step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        idle(int'(DEPTH + L) + 4, 1'b1);
        chk("mix_drained", 32'(q.size()), 32'd0);

        // Reset with 2 results buffered and 3 regular ops in flight.
        for (int i = 0; i < 5; i++)
            step(1'b1, OP_MUL, 16'(16'h1000 + i), 16'h4000, 1'b0, 1'b0, 16'h0, 1'b0);
        rst = 1'b0;
        q.delete();
        mcnt = 0;
        idle(2, 1'b1);
        rst = 1'b1;
        idle(int'(L) + 3, 1'b1);
        chk("post_reset_out_valid", 32'(out_valid), 32'd0);

        // Still functional after reset.
        step(1'b1, OP_MUL, 16'h2345, 16'h4000, 1'b1, 1'b0, 16'h0, 1'b0);
        idle(int'(L) + 3, 1'b1);
        chk("final_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ppu_special_bypass.md
Name: ppu_special_bypass

Overview:
- Front-end dispatcher and in-order result merger around the fixed-latency posit arithmetic core.
- Classifies each incoming operation as special/trivial or regular:
  - Special means an operand is ZERO or NAR, or the result is trivially ZERO.
  - Special operations are resolved by an internal handle_special_or_trivial instance.
  - Regular operations are issued to the core.
- Results leave in issue order through a valid/ready output buffer that absorbs backpressure the core cannot.

Parameters:
- N, 16, posit width; ZERO = all zeros, NAR = MSB only (ppu_pkg).
- CORE_LATENCY, 3, cycles from core issue to core_pout valid; must be >= 1.
- DEPTH, CORE_LATENCY+2, output FIFO entries and in-flight credit limit.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation can be accepted.
- op  in  OP_BITS  ADD/SUB/MUL/DIV (ppu_pkg encoding).
- p1  in  N  operand 1.
- p2  in  N  operand 2.
- core_valid  out  1  issue strobe to core.
- core_op  out  OP_BITS  op passed through, combinational.
- core_p1  out  N  p1 passed through.
- core_p2  out  N  p2 passed through.
- core_pout  in  N  core result, valid exactly CORE_LATENCY cycles after its issue cycle.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- pout  out  N  result.
- out_special  out  1  result came from the special path.

Behaviour:
- Accept: acc = in_valid && in_ready.
- Special classification, combinational on the inputs. An operation is special if any of:
  - p1 or p2 is ZERO or NAR;
  - op==ADD and p2 == two's complement of p1;
  - op==SUB and p1 == p2.
- Special results come from the internal handle_special_or_trivial (same N, fed op/p1/p2).
  - Examples: ZERO*x=ZERO; x/ZERO=NAR; x+(-x)=ZERO; any NAR operand gives NAR.
- core_valid = acc && !special, combinational in the accept cycle. The core is never issued special ops.
- Delay line: CORE_LATENCY registered stages of {valid, special, special_result}.
  - Stage 1 loads {acc, special, lut result} each cycle.
  - Stage k loads from stage k-1 unconditionally; the line never stalls.
- Merge at the last stage when its valid is 1:
  - push {special ? special_result : core_pout, special} into the FIFO at the clock edge.
  - An op accepted in cycle t is written at the end of cycle t+CORE_LATENCY.
  - With an empty FIFO it shows out_valid in cycle t+CORE_LATENCY+1. Minimum latency is CORE_LATENCY+1 cycles for both paths.
- Ordering: results always leave in acceptance order, whatever the mix of special and regular ops.
- Output FIFO: DEPTH entries, first-word-fall-through.
  - out_valid = !empty; pout/out_special show the head entry.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle is allowed, including on a full FIFO after the pop.
- Credit counter cnt (0..DEPTH) counts accepted ops not yet popped.
  - +1 on acc, -1 on pop, unchanged when both occur in one cycle.
  - in_ready = (cnt < DEPTH), registered-state only, with no combinational path from out_ready.
  - This bound guarantees the FIFO never overflows. The design must not drop or overwrite entries.
- Throughput: one op per cycle sustained when out_ready is held at 1.
- out_ready=0 for long: the in-flight ops drain into the FIFO; in_ready stays 0 while cnt==DEPTH.
- Reset (asserted, async), including mid-operation:
  - all delay-line valids 0, FIFO empty, cnt 0;
  - out_valid 0, core_valid 0, in_ready 1 once released;
  - in-flight ops are discarded, and any core_pout arriving after reset is ignored.
- Outputs with no valid: pout/out_special hold the last head value or 0; they must not be relied on when out_valid=0.

Test Plan (N=16, CORE_LATENCY=3):
- Regular op: MUL 0x4000,0x4000 at t=0, core returns 0x4000 at t=3 -> core_valid=1 at t=0; out_valid=1 at t=4 with pout=0x4000, out_special=0.
- Special ops, one per cycle: MUL 0x0000,0x4000; DIV 0x4000,0x0000; ADD 0x4000,0xC000; SUB 0x3000,0x3000; ADD 0x8000,0x1000 -> core_valid=0 for all; outputs 0x0000, 0x8000, 0x0000, 0x0000, 0x8000 from t=4, all out_special=1.
- Interleave: regular, special, regular, special back-to-back -> results leave in the same order, one per cycle, with correct out_special flags.
- Backpressure: out_ready=0 while issuing every cycle -> in_ready drops after exactly DEPTH=5 accepts, no loss. Then out_ready=1 -> 5 results in order, and in_ready returns the cycle after the first pop.
- Simultaneous events: cnt==DEPTH with out_ready=1 and in_valid=1 -> pop this cycle, in_ready=1 next cycle, cnt returns to DEPTH. Full-throughput stream of 100 mixed ops -> zero bubbles.
- Reset mid-operation: assert rst low with 3 ops in flight and 2 in the FIFO -> out_valid=0, in_ready=1 after release. A stale core_pout after release produces no output.
